fpadd_sequencer: RTL and testbench

Control FSM for the single-precision floating-point adder datapath. Accepts an operand pair through a valid/ready handshake and drives the operand bus. Steps the datapath through its mask, align, ALU and normalize stages with one-hot stage enables, then holds the finished result until the consumer accepts it. Sits between the upstream operand source and the adder datapath; owns all sequencing so the datapath stages stay purely combinational/registered slices.

---
 rtl/fpadd_sequencer.sv | 147 ++++++++++++++
 tb/tb_fpadd_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_sequencer.sv
// fpadd_sequencer
//   Control FSM for the single-precision floating-point adder datapath.
//   Accepts an operand pair (valid/ready), drives it onto the datapath
//   operand buses, walks the datapath through MASK -> ALIGN -> ALU -> NORM
//   with one-hot stage enables, and holds the finished sum until the
//   consumer takes it.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream operand handshake; in_a/in_b operands
//   bus_a, bus_b        latched operands driven to the datapath
//   mask_en, align_en,
//   alu_en, norm_en     one-hot datapath stage enables
//   norm_done,dp_result datapath normalize-complete flag and result word
//   out_valid/out_ready downstream handshake; out_result, out_timeout
//   busy                high whenever not IDLE
//   op_count            saturating count of completed operations
module fpadd_sequencer #(
    parameter int NORM_MAX = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] bus_a,
    output logic [31:0] bus_b,
    output logic        mask_en,
    output logic        align_en,
    output logic        alu_en,
    output logic        norm_en,
    input  logic        norm_done,
    input  logic [31:0] dp_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_timeout,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam logic [7:0] NORM_LIMIT = 8'(NORM_MAX);

    typedef enum logic [2:0] {
        IDLE,
        MASK,
        ALIGN,
        ALU,
        NORM,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] norm_cnt;
    logic       accept;
    logic       norm_hit;
    logic       release_out;

    // norm_cnt counts NORM cycles already completed, so the cycle in
    // progress is number norm_cnt+1.
    assign accept      = (state == IDLE) && in_valid;
    assign norm_hit    = (norm_cnt + 8'd1) == NORM_LIMIT;
    assign release_out = (state == DONE) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mask_en    = 1'b0;
        align_en   = 1'b0;
        alu_en     = 1'b0;
        norm_en    = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = MASK;
            end
            MASK: begin
                mask_en    = 1'b1;
                state_next = ALIGN;
            end
            ALIGN: begin
                align_en   = 1'b1;
                state_next = ALU;
            end
            ALU: begin
                alu_en     = 1'b1;
                state_next = NORM;
            end
            NORM: begin
                norm_en = 1'b1;
                if (norm_done || norm_hit) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_a       <= 32'h0;
            bus_b       <= 32'h0;
            norm_cnt    <= 8'h0;
            out_result  <= 32'h0;
            out_timeout <= 1'b0;
            op_count    <= 16'h0;
        end else begin
            if (accept) begin
                bus_a    <= in_a;
                bus_b    <= in_b;
                norm_cnt <= 8'h0;
            end
            if (state == NORM) begin
                norm_cnt <= norm_cnt + 8'd1;
                // A completion on the last allowed cycle beats the timeout.
                if (norm_done) begin
                    out_result  <= dp_result;
                    out_timeout <= 1'b0;
                end else if (norm_hit) begin
                    out_result  <= 32'h0;
                    out_timeout <= 1'b1;
                end
            end
            if (release_out && (op_count != 16'hFFFF)) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fpadd_sequencer.sv
module tb_fpadd_sequencer;

    localparam int NORM_MAX = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'h0;
    logic [31:0] in_b = 32'h0;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic        mask_en;
    logic        align_en;
    logic        alu_en;
    logic        norm_en;
    logic        norm_done = 1'b0;
    logic [31:0] dp_result = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_timeout;
    logic        busy;
    logic [15:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;
    int model_count = 0;

    fpadd_sequencer #(.NORM_MAX(NORM_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .bus_a(bus_a), .bus_b(bus_b),
        .mask_en(mask_en), .align_en(align_en), .alu_en(alu_en), .norm_en(norm_en),
        .norm_done(norm_done), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_timeout(out_timeout),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // One operation from the caller's current negedge (state IDLE).
    // k: NORM cycle (1-based) on which the datapath reports done; 0 = never.
    // hold: DONE cycles with out_ready low before release.
    // abort_c: return early at that cycle (0 = run to completion).
    // Ends at the negedge of the IDLE cycle following release.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] dp, input int k, input int hold,
                          input int abort_c);
        int          nc;
        bit          tmo;
        logic [31:0] exp_res;
        logic [3:0]  exp_en;
        tmo     = !(k >= 1 && k <= NORM_MAX);
        nc      = tmo ? NORM_MAX : k;
        exp_res = tmo ? 32'h0 : dp;

        in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL accept_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        for (int c = 1; c <= 4 + nc; c++) begin
            @(negedge clk);
            if (c == abort_c) return;
            in_valid  = 1'($urandom);
            in_a      = $urandom;
            in_b      = $urandom;
            dp_result = $urandom;
            if (c >= 4 && c < 4 + nc) begin
                norm_done = (c - 3 == k);
                if (norm_done) dp_result = dp;
            end else begin
                norm_done = 1'($urandom);
            end
            exp_en = {c == 1, c == 2, c == 3, (c >= 4 && c < 4 + nc)};
            n_tests++;
            if ({mask_en, align_en, alu_en, norm_en} !== exp_en) begin
                n_fail++;
                $display("FAIL enables cycle %0d: got %b expected %b", c,
                         {mask_en, align_en, alu_en, norm_en}, exp_en);
            end
            n_tests++;
            if ({out_valid, busy, in_ready} !== {c == 4 + nc, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL valid_busy_ready cycle %0d: got %b expected %b", c,
                         {out_valid, busy, in_ready}, {c == 4 + nc, 1'b1, 1'b0});
            end
            n_tests++;
            if ({bus_a, bus_b} !== {a, b}) begin
                n_fail++;
                $display("FAIL bus cycle %0d: got %h/%h expected %h/%h", c, bus_a, bus_b, a, b);
            end
        end

        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(negedge clk);
                in_valid  = 1'($urandom);
                norm_done = 1'($urandom);
            end
            n_tests++;
            if ({out_valid, in_ready, out_timeout, out_result} !== {1'b1, 1'b0, tmo, exp_res}) begin
                n_fail++;
                $display("FAIL done_hold %0d: got v=%b r=%b t=%b res=%h expected v=1 r=0 t=%b res=%h",
                         h, out_valid, in_ready, out_timeout, out_result, tmo, exp_res);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0; norm_done = 1'b0;
        if (model_count < 65535) model_count++;
        n_tests++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL release: got v=%b r=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
        end
        n_tests++;
        if (op_count !== 16'(model_count)) begin
            n_fail++; $display("FAIL op_count: got %0d expected %0d", op_count, model_count);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus_a, bus_b, out_result} !== 96'h0 ||
            {out_valid, out_timeout, mask_en, align_en, alu_en, norm_en, busy} !== 7'h0 ||
            op_count !== 16'h0) begin
            n_fail++; $display("FAIL reset_outputs: got res=%h op=%0d busy=%b expected zeros",
                               out_result, op_count, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic;
        run_op(32'h3F800000, 32'h40000000, 32'h40400000, 1, 0, 0);
    endtask

    task automatic test_backpressure;
        run_op(32'h41200000, 32'hC0A00000, 32'h40A00000, 2, 10, 0);
    endtask

    task automatic test_variable_norm;
        run_op(32'h3F000000, 32'h3E800000, 32'h3F400000, 7, 1, 0);
    endtask

    task automatic test_timeout;
        run_op(32'h7F000000, 32'h00000001, 32'hDEADBEEF, 0, 0, 0);
        run_op(32'h12345678, 32'h9ABCDEF0, 32'h4B000001, NORM_MAX, 0, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++)
            run_op($urandom, $urandom, $urandom, 1 + (i % 3), 0, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++)
            run_op($urandom, $urandom, $urandom, int'($urandom_range(0, 30)),
                   int'($urandom_range(0, 3)), 0);
    endtask

    task automatic test_reset_mid_norm;
        run_op(32'hCAFEF00D, 32'h0BADBEEF, 32'h0, 0, 0, 8);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus_a, bus_b, out_result} !== 96'h0 ||
            {out_valid, out_timeout, mask_en, align_en, alu_en, norm_en, busy} !== 7'h0 ||
            op_count !== 16'h0) begin
            n_fail++; $display("FAIL midnorm_reset: got bus=%h res=%h op=%0d en=%b busy=%b expected zeros",
                               bus_a, out_result, op_count, {mask_en, align_en, alu_en, norm_en}, busy);
        end
        in_valid = 1'b0; norm_done = 1'b0; model_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            n_fail++; $display("FAIL midnorm_release: got %b expected 100", {in_ready, busy, out_valid});
        end
        run_op(32'h3F800000, 32'h3F800000, 32'h40000000, 1, 0, 0);
    endtask

    task automatic test_saturation;
        force dut.op_count = 16'hFFFE;
        #1;
        release dut.op_count;
        model_count = 65534;
        run_op($urandom, $urandom, $urandom, 3, 0, 0);
        run_op($urandom, $urandom, $urandom, 0, 0, 0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_variable_norm;
        test_timeout;
        test_back_to_back;
        test_random;
        test_reset_mid_norm;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
